// File: rtl/mult_prod_accum.sv
// mult_prod_accum: sums each group of BURST_LEN unsigned 16-bit products
// from the multiplier and presents the burst total, with a carry-out
// (overflow) flag, on a valid/ready output port.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds valid and its payload
// stable until that transfer. in_ready is decoded from registered state only,
// so there is no combinational path from out_ready to in_ready.
module mult_prod_accum #(
  parameter int BURST_LEN = 4,
  parameter int ACC_W     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             dbg_state
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  // ACC: accepting products. HOLD: a finished burst waits on the output port.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             carry;

  // One extra bit on the adder captures the carry out of the accumulator.
  always_comb begin
    sum   = {1'b0, acc} + (ACC_W + 1)'(in_p);
    carry = sum[ACC_W];
  end

  assign in_ready  = (state == ACC);
  assign dbg_state = (state == HOLD);

  // Burst accumulation, result hand-off and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      // A pending result and any partial burst are dropped; a product
      // offered in this cycle is not counted.
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            if (cnt == CNT_LAST) begin
              out_sum   <= sum[ACC_W-1:0];
              out_ovf   <= ovf | carry;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= HOLD;
            end else begin
              acc <= sum[ACC_W-1:0];
              cnt <= cnt + CNT_W'(1);
              ovf <= ovf | carry;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_prod_accum.sv
// Bench for mult_prod_accum: three instances (default, ACC_W=16, BURST_LEN=1)
// share one stimulus stream; a sum-of-products reference model checks every
// cycle, with table vectors and directed corner sequences on top.
module tb_mult_prod_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     = 1'b0;
  logic        clr       = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_p      = '0;

  logic [2:0]  rdy, vld, ovfo, dbg;
  logic [23:0] sum0, sum2;
  logic [15:0] sum1;

  int checks = 0;
  int errors = 0;

  mult_prod_accum #(.BURST_LEN(4), .ACC_W(24)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_p(in_p), .out_valid(vld[0]), .out_ready(out_ready), .out_sum(sum0),
    .out_ovf(ovfo[0]), .dbg_state(dbg[0]));

  mult_prod_accum #(.BURST_LEN(4), .ACC_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_p(in_p), .out_valid(vld[1]), .out_ready(out_ready), .out_sum(sum1),
    .out_ovf(ovfo[1]), .dbg_state(dbg[1]));

  mult_prod_accum #(.BURST_LEN(1), .ACC_W(24)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_p(in_p), .out_valid(vld[2]), .out_ready(out_ready), .out_sum(sum2),
    .out_ovf(ovfo[2]), .dbg_state(dbg[2]));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sum_of(input int i);
    case (i)
      0:       return longint'(sum0);
      1:       return longint'(sum1);
      default: return longint'(sum2);
    endcase
  endfunction

  // ---------------- reference model ----------------
  localparam int W_A  [3] = '{24, 16, 24};
  localparam int BL_A [3] = '{4, 4, 1};

  int     m_cnt   [3];
  longint m_tot   [3];
  bit     m_hold  [3];
  longint m_sum   [3];
  bit     m_ovf   [3];
  bit     m_known [3] = '{1'b1, 1'b1, 1'b1};
  logic [23:0] exp_q[$];

  // Each burst's true total; result is total mod 2^W, overflow iff total >= 2^W.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0; m_tot[i] = 0; m_hold[i] = 0;
        m_sum[i] = 0; m_ovf[i] = 0; m_known[i] = 1;
      end
      exp_q.delete();
    end else if (clr) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0; m_tot[i] = 0; m_hold[i] = 0; m_known[i] = 0;
      end
      exp_q.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_hold[i]) begin
          if (out_ready) m_hold[i] = 0;
        end else if (in_valid) begin
          m_tot[i] += longint'(in_p);
          m_cnt[i]++;
          if (m_cnt[i] == BL_A[i]) begin
            m_sum[i]   = m_tot[i] % (longint'(1) << W_A[i]);
            m_ovf[i]   = (m_tot[i] >= (longint'(1) << W_A[i]));
            m_hold[i]  = 1;
            m_known[i] = 1;
            m_cnt[i]   = 0;
            m_tot[i]   = 0;
            if (i == 0) exp_q.push_back(24'(m_sum[i]));
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_out_valid", i), longint'(vld[i]), longint'(m_hold[i]));
      chk($sformatf("u%0d_in_ready", i), longint'(rdy[i]), longint'(!m_hold[i]));
      chk($sformatf("u%0d_dbg_state", i), longint'(dbg[i]), longint'(m_hold[i]));
      if (m_known[i]) begin
        chk($sformatf("u%0d_out_sum", i), sum_of(i), m_sum[i]);
        chk($sformatf("u%0d_out_ovf", i), longint'(ovfo[i]), longint'(m_ovf[i]));
      end
    end
    // Scoreboard: each delivered result of u0 matches the oldest expected one.
    if (rst_n && !clr && vld[0] && out_ready) begin
      chk("sb_result_pending", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("sb_out_sum", longint'(sum0), longint'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clear with a product offered in the same cycle (it must not count).
  task automatic do_clr();
    clr = 1'b1; in_valid = 1'b1; in_p = 16'd500;
    tick();
    clr = 1'b0; in_valid = 1'b0;
  endtask

  task automatic burst(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    in_valid = 1'b1;
    in_p = a; tick();
    in_p = b; tick();
    in_p = c; tick();
    in_p = d; tick();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] p [4];
    logic [23:0] s24;
    logic        o24;
    logic [15:0] s16;
    logic        o16;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input logic [23:0] s24, input logic o24,
                              input logic [15:0] s16, input logic o16);
    vec_t v;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.s24 = s24; v.o24 = o24; v.s16 = s16; v.o16 = o16;
    return v;
  endfunction

  vec_t tv [7];

  initial begin
    tv[0] = mk(150, 100, 0, 254, 504, 0, 504, 0);
    tv[1] = mk(1, 2, 3, 4, 10, 0, 10, 0);
    tv[2] = mk(65025, 1000, 0, 0, 66025, 0, 489, 1);
    tv[3] = mk(1, 1, 1, 1, 4, 0, 4, 0);
    tv[4] = mk(65025, 65025, 65025, 65025, 260100, 0, 63492, 1);
    tv[5] = mk(65535, 65535, 65535, 65535, 262140, 0, 65532, 1);
    tv[6] = mk(10, 10, 10, 10, 40, 0, 40, 0);

    // Reset values
    tick(); tick();
    chk("rst_in_ready", longint'(rdy[0]), 1);
    chk("rst_out_valid", longint'(vld[0]), 0);
    chk("rst_out_sum", longint'(sum0), 0);
    chk("rst_out_ovf", longint'(ovfo[0]), 0);
    rst_n = 1'b1;
    tick();

    // Table vectors, out_ready high: result visible for exactly one cycle.
    do_clr();
    out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      burst(tv[v].p[0], tv[v].p[1], tv[v].p[2], tv[v].p[3]);
      chk($sformatf("tv%0d_valid", v), longint'(vld[0]), 1);
      chk($sformatf("tv%0d_in_ready_low", v), longint'(rdy[0]), 0);
      chk($sformatf("tv%0d_sum24", v), longint'(sum0), longint'(tv[v].s24));
      chk($sformatf("tv%0d_ovf24", v), longint'(ovfo[0]), longint'(tv[v].o24));
      chk($sformatf("tv%0d_sum16", v), longint'(sum1), longint'(tv[v].s16));
      chk($sformatf("tv%0d_ovf16", v), longint'(ovfo[1]), longint'(tv[v].o16));
      tick();
      chk($sformatf("tv%0d_valid_one_cycle", v), longint'(vld[0]), 0);
      chk($sformatf("tv%0d_in_ready_back", v), longint'(rdy[0]), 1);
    end

    // Backpressure: result holds, inputs ignored, then next burst is clean.
    do_clr();
    out_ready = 1'b0;
    burst(150, 100, 0, 254);
    in_valid = 1'b1; in_p = 16'd999;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", longint'(vld[0]), 1);
      chk("bp_sum", longint'(sum0), 504);
      chk("bp_in_ready", longint'(rdy[0]), 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_released", longint'(vld[0]), 0);
    burst(1, 2, 3, 4);
    chk("bp_next_sum", longint'(sum0), 10);
    tick();

    // Gaps: in_valid low on alternate cycles.
    do_clr();
    for (int k = 0; k < 7; k++) begin
      in_valid = (k % 2 == 0); in_p = 16'd65025;
      tick();
      if (k < 6) chk("gap_no_early_valid", longint'(vld[0]), 0);
    end
    in_valid = 1'b0;
    chk("gap_valid", longint'(vld[0]), 1);
    chk("gap_sum24", longint'(sum0), 260100);
    chk("gap_sum16", longint'(sum1), 63492);
    chk("gap_ovf16", longint'(ovfo[1]), 1);
    tick();

    // clr after two products discards the partial sum.
    in_valid = 1'b1; in_p = 16'd5; tick(); in_p = 16'd7; tick();
    in_valid = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    burst(10, 10, 10, 10);
    chk("clr_partial_sum", longint'(sum0), 40);
    tick();

    // clr during HOLD drops out_valid.
    out_ready = 1'b0;
    burst(1, 2, 3, 4);
    chk("clr_hold_valid", longint'(vld[0]), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_hold_dropped", longint'(vld[0]), 0);
    chk("clr_hold_in_ready", longint'(rdy[0]), 1);

    // Asynchronous reset in HOLD and mid-burst.
    burst(150, 100, 0, 254);
    chk("rst_hold_valid_before", longint'(vld[0]), 1);
    rst_n = 1'b0; #1;
    chk("arst_valid", longint'(vld[0]), 0);
    chk("arst_in_ready", longint'(rdy[0]), 1);
    chk("arst_sum", longint'(sum0), 0);
    chk("arst_sum16", longint'(sum1), 0);
    tick(); rst_n = 1'b1; out_ready = 1'b1; tick();
    in_valid = 1'b1; in_p = 16'd300; tick(); tick();
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    chk("arst_mid_in_ready", longint'(rdy[0]), 1);
    tick(); rst_n = 1'b1; tick();
    chk("arst_after_in_ready", longint'(rdy[0]), 1);
    burst(1, 2, 3, 4);
    chk("arst_partial_lost", longint'(sum0), 10);
    tick();

    // BURST_LEN = 1: every product is its own burst.
    do_clr();
    out_ready = 1'b1;
    in_valid = 1'b1; in_p = 16'd7; tick();
    chk("bl1_valid_a", longint'(vld[2]), 1);
    chk("bl1_sum_a", longint'(sum2), 7);
    chk("bl1_in_ready_a", longint'(rdy[2]), 0);
    in_p = 16'd9; tick();
    chk("bl1_gap", longint'(vld[2]), 0);
    chk("bl1_in_ready_gap", longint'(rdy[2]), 1);
    tick();
    chk("bl1_valid_b", longint'(vld[2]), 1);
    chk("bl1_sum_b", longint'(sum2), 9);
    in_valid = 1'b0; tick();
    chk("bl1_done", longint'(vld[2]), 0);

    // Randomized traffic, checked every cycle by the model.
    do_clr();
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = $urandom_range(0, 5);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_p      = (sel == 0) ? 16'd65025 : (sel == 1) ? 16'd65535 : 16'($urandom_range(0, 65535));
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      tick();
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Run-time bound.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
